per2axi_req_arbiter: RTL and testbench
======================================

# per2axi_req_arbiter

Round-robin arbiter that shares one per2axi peripheral request channel between NB_REQ peripheral-interconnect requesters. It enforces a per-requester cap on outstanding transactions and stamps each forwarded request with a one-hot ID. It also routes response valids back to the requester that owns them. It sits between the cluster peripheral interconnect ports and the per2axi bridge request/response channels.

## Interface
- NB_REQ, 4: number of requesters; also the width of the one-hot ID.
- PER_ADDR_WIDTH, 32: peripheral address width.
- MAX_OUTST, 4: maximum in-flight transactions per requester, range 1..15.
- CNT_WIDTH, $clog2(MAX_OUTST+1): outstanding counter width. Derived; do not override.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NB_REQ  per-requester request.
- add_i  in  NB_REQ x PER_ADDR_WIDTH  per-requester address.
- we_i  in  NB_REQ  per-requester we; passed through unchanged, no polarity interpretation.
- atop_i  in  NB_REQ x 6  per-requester atomic opcode.
- wdata_i  in  NB_REQ x 32  per-requester write data.
- be_i  in  NB_REQ x 4  per-requester byte enables.
- gnt_o  out  NB_REQ  per-requester grant.
- per_req_o  out  1  request to the bridge.
- per_add_o, per_we_o, per_atop_o, per_wdata_o, per_be_o  out  as above  fields of the selected requester.
- per_id_o  out  NB_REQ  one-hot ID; bit i set means the request came from requester i.
- per_gnt_i  in  1  bridge grant.
- rsp_valid_i  in  1  response valid from the bridge.
- rsp_id_i  in  NB_REQ  one-hot ID of the response.
- rsp_valid_o  out  NB_REQ  per-requester response valid.
- rsp_err_o  out  1  registered one-cycle pulse on an unexpected response.

## Operation
- Eligibility: elig[i] = req_i[i] and cnt[i] < MAX_OUTST.
- State registers:
  - rr_ptr: requester index with highest priority.
  - lock, lock_idx: hold state for an ungranted request.
  - cnt[i] for every requester: outstanding transactions.
  - rsp_err_o register.
- Selection, two states, UNLOCKED and LOCKED:
  - UNLOCKED: winner is the first eligible index scanning rr_ptr, rr_ptr+1, … mod NB_REQ.
  - LOCKED: winner = lock_idx regardless of eligibility. Once a request is presented it must not change until granted, which keeps AXI valid stable downstream.
- per_req_o = 1 if LOCKED, or if any elig bit is set. All per_* fields and per_id_o are muxed from the winner. When per_req_o = 0, fields are 0 and per_id_o = 0.
- Handshake: hs = per_req_o and per_gnt_i. gnt_o[winner] = hs; all other gnt_o bits are 0.
- Transitions:
  - UNLOCKED → LOCKED when per_req_o and not per_gnt_i; lock_idx <= winner.
  - LOCKED → UNLOCKED on hs.
  - If a locked requester drops req_i, that is a requester protocol violation. The block stays LOCKED and keeps driving the held index.
- rr_ptr <= (winner+1) mod NB_REQ on hs only; otherwise it holds.
- Counters:
  - inc[i] = hs and winner == i.
  - dec[i] = rsp_valid_i and rsp_id_i[i].
  - Both set: cnt unchanged. inc only: +1. dec only: −1.
  - dec with cnt[i] = 0: cnt stays 0, and rsp_err_o = 1 on the next cycle.
  - Upper saturation is impossible by construction, since inc requires cnt < MAX_OUTST.
- rsp_valid_o[i] = rsp_valid_i and rsp_id_i[i], combinational. A rsp_id_i with more than one bit set decrements every flagged counter; this is a bridge violation and must be flagged by an assertion in simulation only.

## Timing
- Request path is combinational: requester to per_req_o, and per_gnt_i to gnt_o, both zero-cycle. Grant appears in the same cycle as per_gnt_i.
- cnt, rr_ptr and lock update on the edge after the event. A requester at MAX_OUTST−1 that is granted in cycle n is ineligible from cycle n+1.
- A response in cycle n frees a slot, and the requester is eligible in cycle n+1. A response and a new grant in the same cycle leave the count net unchanged.
- Reset values, applied on any clock edge with rst_i = 1, including mid-transaction:
  - rr_ptr = 0, UNLOCKED, all cnt = 0, rsp_err_o = 0.
  - Combinational outputs then follow from inputs.
  - Responses to pre-reset transactions hit cnt = 0 and raise rsp_err_o.
- rsp_err_o is registered: a pulse of exactly one cycle per offending cycle, asserted in the cycle after the response.

## Test plan
- Fairness, 4 requesters: all req_i held high, per_gnt_i = 1, responses returned immediately. Grants follow 0,1,2,3,0,…; per_id_o = 0001, 0010, 0100, 1000.
- Lock: req_i = 0011, per_gnt_i = 0 for 3 cycles, then 1. per_id_o stays 0001 all 4 cycles with fields stable; gnt_o = 0001 only in cycle 4. The next grant goes to requester 1.
- Outstanding cap, MAX_OUTST = 4, no responses: requester 2 alone gets 4 grants, then per_req_o = 0. One response with rsp_id_i = 0100 makes per_req_o = 1 one cycle later.
- Simultaneous grant and response to requester 0 at cnt = 2: cnt stays 2, and rsp_valid_o = 0001 in the same cycle.
- Unexpected response: after reset, rsp_valid_i = 1 with rsp_id_i = 1000. rsp_err_o = 1 for exactly one cycle on the next cycle, and cnt[3] stays 0.
- Reset mid-LOCKED with cnt = {1,2,0,3}: rst_i high for one edge. UNLOCKED, rr_ptr = 0, all counts 0; requester 3 is eligible immediately after.

Source files
------------

// File: rtl/per2axi_req_arbiter.sv
// Round-robin arbiter sharing one per2axi request channel among NB_REQ requesters, with per-requester outstanding cap and one-hot IDs.
// Zero-cycle request/grant path; an ungranted request is held locked until per_gnt_i, and capped requesters are masked.
module per2axi_req_arbiter #(
  parameter int NB_REQ         = 4,
  parameter int PER_ADDR_WIDTH = 32,
  parameter int MAX_OUTST      = 4,
  localparam int CNT_WIDTH     = $clog2(MAX_OUTST + 1)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NB_REQ-1:0]                        req_i,
  input  logic [NB_REQ-1:0][PER_ADDR_WIDTH-1:0]    add_i,
  input  logic [NB_REQ-1:0]                        we_i,
  input  logic [NB_REQ-1:0][5:0]                   atop_i,
  input  logic [NB_REQ-1:0][31:0]                  wdata_i,
  input  logic [NB_REQ-1:0][3:0]                   be_i,
  output logic [NB_REQ-1:0]                        gnt_o,
  output logic                                     per_req_o,
  output logic [PER_ADDR_WIDTH-1:0]                per_add_o,
  output logic                                     per_we_o,
  output logic [5:0]                               per_atop_o,
  output logic [31:0]                              per_wdata_o,
  output logic [3:0]                               per_be_o,
  output logic [NB_REQ-1:0]                        per_id_o,
  input  logic                                     per_gnt_i,
  input  logic                                     rsp_valid_i,
  input  logic [NB_REQ-1:0]                        rsp_id_i,
  output logic [NB_REQ-1:0]                        rsp_valid_o,
  output logic                                     rsp_err_o
);

  localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e                           state_q;
  logic [IDX_W-1:0]                 rr_ptr_q, lock_idx_q;
  logic [NB_REQ-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                             rsp_err_d;

  logic [NB_REQ-1:0] elig, inc, dec;
  logic [IDX_W-1:0]  winner, cand;
  logic              sel_vld, hs;

  always_comb begin
    for (int i = 0; i < NB_REQ; i++) begin
      elig[i] = req_i[i] && (cnt_q[i] < CNT_WIDTH'(MAX_OUTST));
    end
  end

  // Scan downwards so the last hit is the eligible index closest to rr_ptr.
  always_comb begin
    winner  = rr_ptr_q;
    sel_vld = 1'b0;
    cand    = '0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NB_REQ);
      if (elig[cand]) begin
        winner  = cand;
        sel_vld = 1'b1;
      end
    end
    if (state_q == LOCKED) begin
      winner  = lock_idx_q;
      sel_vld = 1'b1;
    end
  end

  assign per_req_o = sel_vld;
  assign hs        = sel_vld & per_gnt_i;

  always_comb begin
    gnt_o       = '0;
    per_id_o    = '0;
    per_add_o   = '0;
    per_we_o    = 1'b0;
    per_atop_o  = '0;
    per_wdata_o = '0;
    per_be_o    = '0;
    if (sel_vld) begin
      gnt_o[winner]    = per_gnt_i;
      per_id_o[winner] = 1'b1;
      per_add_o        = add_i[winner];
      per_we_o         = we_i[winner];
      per_atop_o       = atop_i[winner];
      per_wdata_o      = wdata_i[winner];
      per_be_o         = be_i[winner];
    end
  end

  assign rsp_valid_o = {NB_REQ{rsp_valid_i}} & rsp_id_i;

  // A response to an idle counter only counts as an error when it would underflow.
  always_comb begin
    rsp_err_d = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      inc[i]   = hs && (winner == IDX_W'(i));
      dec[i]   = rsp_valid_i && rsp_id_i[i];
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q[i] == '0) begin
          rsp_err_d = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= UNLOCKED;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      rsp_err_o  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rsp_err_o <= rsp_err_d;
      if (hs) begin
        rr_ptr_q <= (winner == IDX_W'(NB_REQ - 1)) ? '0 : winner + IDX_W'(1);
      end
      case (state_q)
        UNLOCKED: begin
          if (sel_vld && !per_gnt_i) begin
            state_q    <= LOCKED;
            lock_idx_q <= winner;
          end
        end
        LOCKED: begin
          if (hs) begin
            state_q <= UNLOCKED;
          end
        end
        default: state_q <= UNLOCKED;
      endcase
    end
  end

  rsp_id_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_valid_i |-> $onehot(rsp_id_i));

endmodule

// File: tb/tb_per2axi_req_arbiter.sv
// Directed bench for per2axi_req_arbiter: stimulus pushes expected grants/responses, a negedge monitor pops and compares.
module tb_per2axi_req_arbiter;

  localparam int NB = 4;
  localparam int AW = 32;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b1;
  logic [NB-1:0]           req_i = '0;
  logic [NB-1:0][AW-1:0]   add_i;
  logic [NB-1:0]           we_i;
  logic [NB-1:0][5:0]      atop_i;
  logic [NB-1:0][31:0]     wdata_i;
  logic [NB-1:0][3:0]      be_i;
  logic [NB-1:0]           gnt_o;
  logic                    per_req_o;
  logic [AW-1:0]           per_add_o;
  logic                    per_we_o;
  logic [5:0]              per_atop_o;
  logic [31:0]             per_wdata_o;
  logic [3:0]              per_be_o;
  logic [NB-1:0]           per_id_o;
  logic                    per_gnt_i = 1'b0;
  logic                    rsp_valid_i = 1'b0;
  logic [NB-1:0]           rsp_id_i = '0;
  logic [NB-1:0]           rsp_valid_o;
  logic                    rsp_err_o;

  always #5 clk_i = ~clk_i;

  per2axi_req_arbiter #(.NB_REQ(NB), .PER_ADDR_WIDTH(AW), .MAX_OUTST(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .add_i(add_i), .we_i(we_i),
    .atop_i(atop_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o),
    .per_req_o(per_req_o), .per_add_o(per_add_o), .per_we_o(per_we_o),
    .per_atop_o(per_atop_o), .per_wdata_o(per_wdata_o), .per_be_o(per_be_o),
    .per_id_o(per_id_o), .per_gnt_i(per_gnt_i), .rsp_valid_i(rsp_valid_i),
    .rsp_id_i(rsp_id_i), .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o)
  );

  int         tests = 0;
  int         fails = 0;
  int         err_exp = 0;
  int         err_seen = 0;
  int         exp_gnt_q[$];
  logic [3:0] exp_rsp_q[$];
  logic [3:0] we_pat = 4'b0101;

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction
  function automatic logic [31:0] addr_of(input int i);
    return 32'hA000_0000 + 32'(i) * 32'h10;
  endfunction
  function automatic logic [31:0] wdata_of(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction
  function automatic logic [5:0] atop_of(input int i);
    return 6'(i + 5);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive after the rising edge, record expectations, return at the falling edge.
  task automatic cyc(input logic rst, input logic [3:0] req, input logic gnt,
                     input logic rv, input logic [3:0] rid, input int win);
    @(posedge clk_i);
    #1;
    rst_i       = rst;
    req_i       = req;
    per_gnt_i   = gnt;
    rsp_valid_i = rv;
    rsp_id_i    = rid;
    if (win >= 0) exp_gnt_q.push_back(win);
    if (rv) exp_rsp_q.push_back(rid);
    @(negedge clk_i);
  endtask

  int         mw;
  logic [3:0] mr;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (gnt_o != '0) begin
        if (exp_gnt_q.size() == 0) begin
          chk("unexpected_grant", 64'(gnt_o), 64'(0));
        end else begin
          mw = exp_gnt_q.pop_front();
          chk("grant", 64'(gnt_o), 64'(oh(mw)));
          chk("per_id", 64'(per_id_o), 64'(oh(mw)));
          chk("per_add", 64'(per_add_o), 64'(addr_of(mw)));
          chk("per_wdata", 64'(per_wdata_o), 64'(wdata_of(mw)));
          chk("per_atop", 64'(per_atop_o), 64'(atop_of(mw)));
          chk("per_be", 64'(per_be_o), 64'(oh(mw)));
          chk("per_we", 64'(per_we_o), 64'(we_pat[mw]));
        end
      end
      if (rsp_valid_o != '0) begin
        if (exp_rsp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid_o), 64'(0));
        end else begin
          mr = exp_rsp_q.pop_front();
          chk("rsp_valid", 64'(rsp_valid_o), 64'(mr));
        end
      end
      if (rsp_err_o) err_seen++;
    end
  end

  initial begin
    for (int i = 0; i < NB; i++) begin
      add_i[i]   = addr_of(i);
      wdata_i[i] = wdata_of(i);
      atop_i[i]  = atop_of(i);
      be_i[i]    = oh(i);
    end
    we_i = we_pat;

    // Reset state
    cyc(1, 4'b0000, 0, 0, 4'b0000, -1);
    chk("rst_per_req", 64'(per_req_o), 64'(0));
    chk("rst_per_id", 64'(per_id_o), 64'(0));
    chk("rst_gnt", 64'(gnt_o), 64'(0));
    chk("rst_err", 64'(rsp_err_o), 64'(0));
    chk("rst_per_add", 64'(per_add_o), 64'(0));
    cyc(1, 4'b0000, 0, 0, 4'b0000, -1);

    // Fairness: every requester always asking, responses one cycle later
    for (int k = 0; k < 8; k++) begin
      cyc(0, 4'b1111, 1, (k > 0), (k == 0) ? 4'b0000 : oh((k + 3) % 4), k % 4);
    end
    cyc(0, 4'b0000, 0, 1, oh(3), -1);
    chk("idle_per_req", 64'(per_req_o), 64'(0));

    // Lock: request 0 held while the bridge stalls, then 1 is served
    for (int c = 0; c < 3; c++) begin
      cyc(0, 4'b0011, 0, 0, 4'b0000, -1);
      chk("lock_per_req", 64'(per_req_o), 64'(1));
      chk("lock_per_id", 64'(per_id_o), 64'(4'b0001));
      chk("lock_gnt", 64'(gnt_o), 64'(0));
      chk("lock_per_add", 64'(per_add_o), 64'(addr_of(0)));
    end
    cyc(0, 4'b0011, 1, 0, 4'b0000, 0);
    cyc(0, 4'b0011, 1, 0, 4'b0000, 1);
    cyc(0, 4'b0000, 0, 1, oh(0), -1);
    cyc(0, 4'b0000, 0, 1, oh(1), -1);

    // Outstanding cap on requester 2
    for (int c = 0; c < 4; c++) cyc(0, 4'b0100, 1, 0, 4'b0000, 2);
    cyc(0, 4'b0100, 1, 0, 4'b0000, -1);
    chk("cap_block", 64'(per_req_o), 64'(0));
    cyc(0, 4'b0100, 1, 1, oh(2), -1);
    chk("cap_block_rsp_cycle", 64'(per_req_o), 64'(0));
    cyc(0, 4'b0100, 1, 0, 4'b0000, 2);
    chk("cap_release", 64'(per_req_o), 64'(1));
    for (int c = 0; c < 4; c++) cyc(0, 4'b0000, 0, 1, oh(2), -1);

    // Same-cycle grant and response on requester 0 at count 2
    cyc(0, 4'b0001, 1, 0, 4'b0000, 0);
    cyc(0, 4'b0001, 1, 0, 4'b0000, 0);
    cyc(0, 4'b0001, 1, 1, oh(0), 0);
    chk("simul_rsp_valid", 64'(rsp_valid_o), 64'(4'b0001));
    chk("simul_gnt", 64'(gnt_o), 64'(4'b0001));
    cyc(0, 4'b0000, 0, 1, oh(0), -1);
    cyc(0, 4'b0000, 0, 1, oh(0), -1);
    chk("simul_no_err", 64'(rsp_err_o), 64'(0));
    cyc(0, 4'b0000, 0, 1, oh(0), -1);
    chk("simul_no_err2", 64'(rsp_err_o), 64'(0));
    err_exp++;
    cyc(0, 4'b0000, 0, 0, 4'b0000, -1);
    chk("simul_err_pulse", 64'(rsp_err_o), 64'(1));
    cyc(0, 4'b0000, 0, 0, 4'b0000, -1);
    chk("simul_err_clear", 64'(rsp_err_o), 64'(0));

    // Unexpected response straight after reset
    cyc(1, 4'b0000, 0, 0, 4'b0000, -1);
    cyc(0, 4'b0000, 0, 1, oh(3), -1);
    chk("unexp_err_same_cycle", 64'(rsp_err_o), 64'(0));
    err_exp++;
    cyc(0, 4'b0000, 0, 0, 4'b0000, -1);
    chk("unexp_err_pulse", 64'(rsp_err_o), 64'(1));
    cyc(0, 4'b0000, 0, 1, oh(3), -1);
    chk("unexp_err_one_cycle", 64'(rsp_err_o), 64'(0));
    err_exp++;
    cyc(0, 4'b0000, 0, 0, 4'b0000, -1);
    chk("unexp_cnt3_still_zero", 64'(rsp_err_o), 64'(1));
    cyc(0, 4'b1000, 1, 0, 4'b0000, 3);
    chk("unexp_req3_eligible", 64'(per_req_o), 64'(1));

    // Reset while locked with counts loaded
    for (int c = 0; c < 3; c++) cyc(0, 4'b0001, 1, 0, 4'b0000, 0);
    cyc(0, 4'b1000, 1, 0, 4'b0000, 3);
    cyc(0, 4'b0100, 1, 0, 4'b0000, 2);
    cyc(0, 4'b0100, 1, 0, 4'b0000, 2);
    cyc(0, 4'b0010, 0, 0, 4'b0000, -1);
    chk("prerst_lock_id", 64'(per_id_o), 64'(4'b0010));
    cyc(1, 4'b0010, 0, 0, 4'b0000, -1);
    cyc(0, 4'b1001, 1, 0, 4'b0000, 0);
    chk("postrst_rr_unlocked", 64'(per_id_o), 64'(4'b0001));
    cyc(0, 4'b1000, 1, 0, 4'b0000, 3);
    chk("postrst_req3", 64'(per_id_o), 64'(4'b1000));
    for (int c = 0; c < 3; c++) cyc(0, 4'b0001, 1, 0, 4'b0000, 0);
    cyc(0, 4'b0001, 1, 0, 4'b0000, -1);
    chk("postrst_cnt0_cap", 64'(per_req_o), 64'(0));
    cyc(0, 4'b0000, 0, 1, oh(2), -1);
    err_exp++;
    cyc(0, 4'b0000, 0, 0, 4'b0000, -1);
    chk("postrst_stale_rsp_err", 64'(rsp_err_o), 64'(1));

    cyc(0, 4'b0000, 0, 0, 4'b0000, -1);
    cyc(0, 4'b0000, 0, 0, 4'b0000, -1);
    chk("grants_outstanding", 64'(exp_gnt_q.size()), 64'(0));
    chk("rsps_outstanding", 64'(exp_rsp_q.size()), 64'(0));
    chk("err_pulse_count", 64'(err_seen), 64'(err_exp));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
